// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side consumer of the async FIFO (rd_clk domain).
// Issues fifo_rd_en, absorbs the FIFO's 1-cycle read latency in a small
// skid buffer and presents a valid/ready stream; flush drains the FIFO.
// Ports:
//   rd_clk, rst_n        clock, async active-low reset
//   fifo_empty           FIFO empty flag
//   fifo_data(_valid)    FIFO read data and its qualifier
//   fifo_rd_en           FIFO read request
//   m_data/m_valid       stream out (head of skid buffer)
//   m_ready              stream ready
//   flush / flush_busy   drain request / high while draining
//   ovf_err              sticky: beat arrived with buffer full
//   occupancy            skid-buffer entries held
//   m_last               burst-end marker (FIFO_RD_STREAM_LAST_EN only)
// Optional feature macro: FIFO_RD_STREAM_LAST_EN (adds m_last and a
// pop counter modulo BURST_LEN; BURST_LEN is otherwise unused).

module fifo_rd_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int SKID_DEPTH = 2,
    parameter int CNT_WIDTH  = 4,
    parameter int BURST_LEN  = 8
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_data_valid,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    input  logic                  flush,
    output logic                  flush_busy,
    output logic                  ovf_err,
`ifdef FIFO_RD_STREAM_LAST_EN
    output logic                  m_last,
`endif
    output logic [CNT_WIDTH-1:0]  occupancy
);

    generate
        if (SKID_DEPTH < 2 || SKID_DEPTH > 8 ||
            (1 << CNT_WIDTH) <= SKID_DEPTH ||
            BURST_LEN < 1) begin : g_bad_param
            $error("fifo_rd_stream: illegal parameters");
        end
    endgenerate

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int PW = $clog2(SKID_DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(SKID_DEPTH - 1);
    localparam logic [CNT_WIDTH:0] DEPTH_W = (CNT_WIDTH+1)'(SKID_DEPTH);

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic                  inflight;
    logic                  in_run;
    logic                  pop;
    logic                  push;
    logic                  full;
    logic                  wr_fire;
    logic [CNT_WIDTH:0]    demand;

    // Non-power-of-2 depths wrap by explicit compare.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign in_run     = (state == RUN);
    assign flush_busy = ~in_run;
    assign m_valid    = (occupancy != '0);
    assign m_data     = m_valid ? mem[rd_ptr] : '0;
    assign pop        = m_valid & m_ready;
    assign push       = fifo_data_valid & in_run;
    assign full       = (occupancy == CNT_WIDTH'(SKID_DEPTH));
    assign wr_fire    = push & ~flush & (~full | pop);

    // Entries held plus the one in flight, minus the one leaving now.
    // Using pop here (m_ready combinationally) keeps 1 beat/cycle.
    assign demand = {1'b0, occupancy}
                  + {{CNT_WIDTH{1'b0}}, inflight}
                  - {{CNT_WIDTH{1'b0}}, pop};

    assign fifo_rd_en = ~fifo_empty & (~in_run | (demand < DEPTH_W));

    always_ff @(posedge rd_clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= fifo_data;
        end
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            inflight  <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
            ovf_err   <= 1'b0;
        end else begin
            inflight <= fifo_rd_en & ~fifo_empty;
            unique case (state)
                RUN: begin
                    if (flush) begin
                        state     <= DRAIN;
                        rd_ptr    <= '0;
                        wr_ptr    <= '0;
                        occupancy <= '0;
                    end else begin
                        if (pop) begin
                            rd_ptr <= ptr_inc(rd_ptr);
                        end
                        if (wr_fire) begin
                            wr_ptr <= ptr_inc(wr_ptr);
                        end
                        if (push & full & ~pop) begin
                            ovf_err <= 1'b1;
                        end
                        case ({wr_fire, pop})
                            2'b10:   occupancy <= occupancy + 1'b1;
                            2'b01:   occupancy <= occupancy - 1'b1;
                            default: occupancy <= occupancy;
                        endcase
                    end
                end
                DRAIN: begin
                    if (~flush & fifo_empty & ~inflight) begin
                        state <= RUN;
                    end
                end
            endcase
        end
    end

`ifdef FIFO_RD_STREAM_LAST_EN
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);

    logic [BW-1:0] beat_cnt;

    assign m_last = m_valid & (beat_cnt == BEAT_LAST);

    // A flush restarts the burst count from beat 1.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (!in_run || flush) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + 1'b1;
        end
    end
`endif

endmodule
